card_dealer: RTL and testbench
==============================

# card_dealer

Sequential card-draw engine for the BlackJack deck. Sits beside the next-address shuffle logic: it drives the current deck address out, consumes the scrambled candidate address that comes back, and skips cards already dealt by probing linearly. It delivers one card per request as rank and suit with a one-cycle valid pulse. It tracks the 52-card dealt set, the remaining count and the deck-exhausted condition for the game controller.

## Interface

Parameters
- none; deck size fixed at 52 (6'd52), 13 ranks × 4 suits

Ports
- Clk  in  1  system clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- New_Deck  in  1  level-sampled; clears dealt set, aborts any draw in progress
- Req  in  1  draw request; sampled only in IDLE
- Addr_j  in  6  candidate address from the next-address generator (function of Addr_i and counter)
- Addr_i  out  6  registered current deck address, fed to the next-address generator
- Card_Vld  out  1  one-cycle pulse, card outputs valid
- Card_Addr  out  6  deck address of the dealt card, 0..51
- Card_Rank  out  4  1..13 (1 = Ace, 11..13 = J/Q/K)
- Card_Suit  out  2  0..3
- Busy  out  1  high when state ≠ IDLE
- Empty  out  1  high when all 52 cards are dealt
- Cards_Left  out  6  undealt cards, 0..52
- Underflow  out  1  one-cycle pulse when Req is sampled while Empty

## Operation

- State: 52-bit Dealt mask, 6-bit Probe register, 2-state FSM: IDLE, PROBE.
- IDLE, New_Deck=0, Req=1, Empty=0: Probe ← norm(Addr_j), go to PROBE.
  - norm(x) = x−52 if x ≥ 52, else x (60 → 8).
- IDLE, Req=1, Empty=1: Underflow pulses; state stays IDLE; nothing else changes.
- PROBE, Dealt[Probe]=1: Probe ← (Probe==51) ? 0 : Probe+1; stay in PROBE.
- PROBE, Dealt[Probe]=0, as a single edge:
  - Dealt[Probe] ← 1; Addr_i ← Probe; Card_Addr ← Probe
  - Card_Rank ← Probe mod 13 + 1; Card_Suit ← Probe / 13
  - Cards_Left ← Cards_Left − 1; Card_Vld ← 1 for the next cycle
  - Return to IDLE.
- Probe loop termination: Empty=0 guarantees a free slot, so at most 52 probes.
- New_Deck=1, any state, priority over Req and probing:
  - Dealt ← 0, Cards_Left ← 52, state ← IDLE; no Card_Vld.
  - Addr_i is preserved so the shuffle sequence continues.
- Empty = (Cards_Left == 0), combinational from the register.
- Rank/suit derivation uses a compare-subtract chain, no divider.

## Timing

- Reset values: Addr_i=0, Dealt=0, Cards_Left=52, Empty=0, state=IDLE, Card_Vld=0, Card_Addr=0, Card_Rank=0, Card_Suit=0, Underflow=0, Busy=0.
- Latency: Req sampled at edge N → Card_Vld high during cycle after edge N+1+k, where k = number of collisions. Best case 2 cycles.
- Card_Vld is high in an IDLE cycle, so a Req held during that cycle is accepted there. Back-to-back deals run every 2+k cycles.
- Card_Addr/Rank/Suit hold their value until the next deal.
- Addr_i changes only on a deal. Addr_j is sampled only on the accepting edge.
- Underflow is high for exactly one cycle per sampled Req while Empty.
- Reset asserted mid-probe: immediate return to reset values, no pulse.

## Configuration

- DEALER_PROBE_CNT_EN defined: adds output Probe_Cnt[5:0].
  - Holds the collision count k of the last deal, updated with Card_Vld.
  - Reset value 0; New_Deck does not clear it.
- Undefined: port and counter are absent; all other behaviour is identical.

## Test plan

- Reset, Req=1 with Addr_j=5 → Card_Vld 2 cycles later; Card_Addr=5, Rank=6, Suit=0, Addr_i=5, Cards_Left=51.
- After dealing 5, Req with Addr_j=5 → 1 collision; Card_Vld 3 cycles after Req; Card_Addr=6, Rank=7; Probe_Cnt=1 when enabled.
- Deal 51 (Rank=13, Suit=3), then Req with Addr_j=51 → wraps; Card_Addr=0, Rank=1, Suit=0.
- Addr_j=60 on fresh deck → Card_Addr=8, Rank=9, Suit=0.
- 52 successful Reqs → Empty=1, Cards_Left=0, each address 0..51 dealt exactly once. 53rd Req → Underflow pulse, no Card_Vld.
- New_Deck asserted during a 10-collision probe run → no Card_Vld, Busy=0 next cycle, Cards_Left=52, Addr_i unchanged.

Source files
------------

// File: rtl/card_dealer.sv
// Card-draw engine: takes a scrambled candidate address, probes linearly past dealt cards, delivers rank/suit.
// Optional macro DEALER_PROBE_CNT_EN adds the Probe_Cnt output (collision count of the last deal).
module card_dealer (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       New_Deck,
  input  logic       Req,
  input  logic [5:0] Addr_j,
  output logic [5:0] Addr_i,
  output logic       Card_Vld,
  output logic [5:0] Card_Addr,
  output logic [3:0] Card_Rank,
  output logic [1:0] Card_Suit,
  output logic       Busy,
  output logic       Empty,
  output logic [5:0] Cards_Left,
  output logic       Underflow
`ifdef DEALER_PROBE_CNT_EN
  ,
  output logic [5:0] Probe_Cnt
`endif
);

  // state | meaning
  // IDLE  | waiting for Req; Card_Vld/Underflow pulses appear here
  // PROBE | walking the deck from the candidate address to the first undealt card
  typedef enum logic {IDLE = 1'b0, PROBE = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [51:0] dealt_q;
  logic [5:0]  probe_q, probe_next, addr_norm;
  logic [5:0]  addr_i_q, card_addr_q, cards_left_q, rem_c;
  logic [3:0]  card_rank_q, rank_c;
  logic [1:0]  card_suit_q, suit_c;
  logic        card_vld_q, underflow_q;
  logic        accept, deal, collide, underflow_d;

  assign addr_norm  = (Addr_j >= 6'd52) ? (Addr_j - 6'd52) : Addr_j;
  assign probe_next = (probe_q == 6'd51) ? 6'd0 : (probe_q + 6'd1);

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    deal        = 1'b0;
    collide     = 1'b0;
    underflow_d = 1'b0;
    if (New_Deck) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (Req) begin
            if (Empty) begin
              underflow_d = 1'b1;
            end else begin
              accept  = 1'b1;
              state_d = PROBE;
            end
          end
        end
        PROBE: begin
          if (dealt_q[probe_q]) begin
            collide = 1'b1;
          end else begin
            deal    = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Divider-free split of the address into suit (quotient by 13) and rank (remainder + 1)
  always_comb begin
    suit_c = 2'd0;
    rem_c  = probe_q;
    if (probe_q >= 6'd39) begin
      suit_c = 2'd3;
      rem_c  = probe_q - 6'd39;
    end else if (probe_q >= 6'd26) begin
      suit_c = 2'd2;
      rem_c  = probe_q - 6'd26;
    end else if (probe_q >= 6'd13) begin
      suit_c = 2'd1;
      rem_c  = probe_q - 6'd13;
    end
    rank_c = rem_c[3:0] + 4'd1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      dealt_q      <= '0;
      probe_q      <= '0;
      addr_i_q     <= '0;
      card_addr_q  <= '0;
      card_rank_q  <= '0;
      card_suit_q  <= '0;
      cards_left_q <= 6'd52;
      card_vld_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      card_vld_q  <= deal;
      underflow_q <= underflow_d;
      if (New_Deck) begin
        dealt_q      <= '0;
        cards_left_q <= 6'd52;
      end
      if (accept)  probe_q <= addr_norm;
      if (collide) probe_q <= probe_next;
      if (deal) begin
        dealt_q[probe_q] <= 1'b1;
        addr_i_q         <= probe_q;
        card_addr_q      <= probe_q;
        card_rank_q      <= rank_c;
        card_suit_q      <= suit_c;
        cards_left_q     <= cards_left_q - 6'd1;
      end
    end
  end

`ifdef DEALER_PROBE_CNT_EN
  logic [5:0] coll_q, probe_cnt_q;

  // Collision tally survives New_Deck on purpose; only reset clears it
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      coll_q      <= '0;
      probe_cnt_q <= '0;
    end else begin
      if (accept)  coll_q      <= '0;
      if (collide) coll_q      <= coll_q + 6'd1;
      if (deal)    probe_cnt_q <= coll_q;
    end
  end

  assign Probe_Cnt = probe_cnt_q;
`endif

  assign Addr_i     = addr_i_q;
  assign Card_Vld   = card_vld_q;
  assign Card_Addr  = card_addr_q;
  assign Card_Rank  = card_rank_q;
  assign Card_Suit  = card_suit_q;
  assign Busy       = (state_q == PROBE);
  assign Empty      = (cards_left_q == 6'd0);
  assign Cards_Left = cards_left_q;
  assign Underflow  = underflow_q;

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: a small dealt-set model predicts address, collisions and latency of each draw.
module tb_card_dealer;
  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       New_Deck = 1'b0;
  logic       Req = 1'b0;
  logic [5:0] Addr_j = '0;
  logic [5:0] Addr_i, Card_Addr, Cards_Left;
  logic       Card_Vld, Busy, Empty, Underflow;
  logic [3:0] Card_Rank;
  logic [1:0] Card_Suit;
`ifdef DEALER_PROBE_CNT_EN
  logic [5:0] Probe_Cnt;
`endif

  card_dealer dut (
    .Clk(Clk), .Rst_n(Rst_n), .New_Deck(New_Deck), .Req(Req), .Addr_j(Addr_j),
    .Addr_i(Addr_i), .Card_Vld(Card_Vld), .Card_Addr(Card_Addr), .Card_Rank(Card_Rank),
    .Card_Suit(Card_Suit), .Busy(Busy), .Empty(Empty), .Cards_Left(Cards_Left),
    .Underflow(Underflow)
`ifdef DEALER_PROBE_CNT_EN
    , .Probe_Cnt(Probe_Cnt)
`endif
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;
  bit mdl_dealt [52];
  int mdl_left = 52;
  int seen [52];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 52; i++) mdl_dealt[i] = 1'b0;
    mdl_left = 52;
  endtask

  task automatic new_deck();
    New_Deck = 1'b1;
    step();
    New_Deck = 1'b0;
    model_clear();
  endtask

  task automatic draw(input logic [5:0] aj, output int got);
    int exp_a, k, n;
    bit done;
    exp_a = (aj >= 52) ? aj - 52 : aj;
    k = 0;
    while (mdl_dealt[exp_a] && k < 52) begin
      exp_a = (exp_a == 51) ? 0 : exp_a + 1;
      k++;
    end
    Req = 1'b1;
    Addr_j = aj;
    step();
    Req = 1'b0;
    chk("busy_probe", Busy, 1);
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      step();
      n++;
      if (Card_Vld === 1'b1) done = 1'b1;
    end
    chk("vld_seen", done, 1);
    chk("latency", n, 1 + k);
    mdl_dealt[exp_a] = 1'b1;
    mdl_left--;
    chk("card_addr", Card_Addr, exp_a);
    chk("card_rank", Card_Rank, exp_a % 13 + 1);
    chk("card_suit", Card_Suit, exp_a / 13);
    chk("addr_i", Addr_i, exp_a);
    chk("cards_left", Cards_Left, mdl_left);
    chk("busy_idle", Busy, 0);
`ifdef DEALER_PROBE_CNT_EN
    chk("probe_cnt", Probe_Cnt, k);
`endif
    got = Card_Addr;
    step();
    chk("vld_pulse", Card_Vld, 0);
  endtask

  initial begin
    int got, ones;
    bit any_vld;

    step();
    chk("rst_addr_i", Addr_i, 0);
    chk("rst_left", Cards_Left, 52);
    chk("rst_empty", Empty, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_vld", Card_Vld, 0);
    chk("rst_rank", Card_Rank, 0);
    chk("rst_underflow", Underflow, 0);
    Rst_n = 1'b1;
    step();

    draw(6'd5, got);
    chk("first_addr", got, 5);
    chk("first_rank", Card_Rank, 6);
    draw(6'd5, got);
    chk("collide_addr", got, 6);
    chk("collide_rank", Card_Rank, 7);
    draw(6'd51, got);
    chk("last_rank", Card_Rank, 13);
    chk("last_suit", Card_Suit, 3);
    draw(6'd51, got);
    chk("wrap_addr", got, 0);
    chk("wrap_rank", Card_Rank, 1);

    new_deck();
    chk("nd_left", Cards_Left, 52);
    chk("nd_addr_i", Addr_i, 0);
    draw(6'd60, got);
    chk("norm_addr", got, 8);
    chk("norm_rank", Card_Rank, 9);
    chk("norm_suit", Card_Suit, 0);

    new_deck();
    for (int i = 0; i < 52; i++) seen[i] = 0;
    for (int i = 0; i < 52; i++) begin
      draw(6'((i * 23 + 7) % 64), got);
      if (got < 52) seen[got]++;
    end
    ones = 0;
    for (int i = 0; i < 52; i++) if (seen[i] == 1) ones++;
    chk("all_dealt_once", ones, 52);
    chk("empty_set", Empty, 1);
    chk("empty_left", Cards_Left, 0);

    Req = 1'b1;
    Addr_j = 6'd3;
    step();
    Req = 1'b0;
    chk("uf_pulse", Underflow, 1);
    chk("uf_busy", Busy, 0);
    chk("uf_vld", Card_Vld, 0);
    step();
    chk("uf_clear", Underflow, 0);
    chk("uf_vld2", Card_Vld, 0);
    chk("uf_left", Cards_Left, 0);

    new_deck();
    chk("nd2_left", Cards_Left, 52);
    chk("nd2_empty", Empty, 0);
    for (int i = 0; i < 10; i++) draw(6'(i), got);
    chk("pre_abort_addr_i", Addr_i, 9);
    Req = 1'b1;
    Addr_j = 6'd0;
    step();
    Req = 1'b0;
    repeat (5) step();
    chk("abort_busy_pre", Busy, 1);
    New_Deck = 1'b1;
    step();
    New_Deck = 1'b0;
    model_clear();
    chk("abort_busy", Busy, 0);
    chk("abort_vld", Card_Vld, 0);
    chk("abort_left", Cards_Left, 52);
    chk("abort_addr_i", Addr_i, 9);
    any_vld = 1'b0;
    repeat (12) begin
      step();
      if (Card_Vld !== 1'b0) any_vld = 1'b1;
    end
    chk("abort_no_vld", any_vld, 0);

    draw(6'd20, got);
    chk("post_abort_addr", got, 20);
    chk("post_abort_suit", Card_Suit, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end
endmodule
